// File: rtl/fmul_arbiter.sv
// Round-robin front end sharing one fmul multiplier between NREQ requesters.
// Operands latch at grant; result and one-hot done pulse return in RESP.
module fmul_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      order_i,
  input  logic [32*NREQ-1:0]   rs1_i,
  input  logic [32*NREQ-1:0]   rs2_i,
  output logic [NREQ-1:0]      accepted_o,
  output logic [NREQ-1:0]      done_o,
  output logic [31:0]          rd_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 fmul_order,
  input  logic                 fmul_accepted,
  input  logic                 fmul_done,
  output logic [31:0]          fmul_rs1,
  output logic [31:0]          fmul_rs2,
  input  logic [31:0]          fmul_rd
);
  localparam int IW = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_g;
  logic [31:0]     r_op1;
  logic [31:0]     r_op2;
  logic [31:0]     r_rd;
  logic [NREQ-1:0] r_done;
  logic            r_err;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_ptr_nxt;
  logic [31:0]     w_rs1_sel;
  logic [31:0]     w_rs2_sel;
  logic [NREQ-1:0] w_win_oh;
  logic [NREQ-1:0] w_g_oh;
  logic            w_grant;

  // Winner is the set request with the smallest rotational distance from r_ptr.
  always_comb begin
    int w_best;
    int w_dist;
    w_best    = 0;
    w_dist    = 0;
    w_found   = 1'b0;
    w_win     = '0;
    w_rs1_sel = '0;
    w_rs2_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_dist = k - int'(r_ptr);
      if (w_dist < 0) w_dist = w_dist + NREQ;
      if (order_i[k] && (!w_found || w_dist < w_best)) begin
        w_best    = w_dist;
        w_found   = 1'b1;
        w_win     = IW'(k);
        w_rs1_sel = rs1_i[32*k +: 32];
        w_rs2_sel = rs2_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    w_win_oh = '0;
    w_g_oh   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_win_oh[k] = (w_win == IW'(k));
      w_g_oh[k]   = (r_g == IW'(k));
    end
  end

  assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  assign w_grant   = (r_state == S_IDLE) && w_found;

  always_comb begin
    w_state_nxt = r_state;
    accepted_o  = '0;
    fmul_order  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          accepted_o  = rst ? '0 : w_win_oh;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        fmul_order = 1'b1;
        if (fmul_accepted) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (fmul_done) w_state_nxt = S_RESP;
      end
      S_RESP: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_rd    <= '0;
      r_done  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      if (w_grant) begin
        r_op1 <= w_rs1_sel;
        r_op2 <= w_rs2_sel;
        r_g   <= w_win;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == S_WAIT && fmul_done) begin
        r_rd   <= fmul_rd;
        r_done <= w_g_oh;
      end
      // A done outside WAIT has no owner; flag it and drop the data.
      if (fmul_done && r_state != S_WAIT) r_err <= 1'b1;
    end
  end

  assign done_o   = r_done;
  assign rd_o     = r_rd;
  assign err_o    = r_err;
  assign busy_o   = (r_state != S_IDLE);
  assign fmul_rs1 = r_op1;
  assign fmul_rs2 = r_op2;

endmodule

// File: doc/fmul_arbiter.md
# fmul_arbiter

Shares one `fmul` single-precision multiplier between NREQ independent requesters (FPU issue ports) using round-robin arbitration. Operands are latched at grant and held stable on the multiplier inputs until its `done`. The result is registered and returned to the owning requester with a one-cycle `done` pulse. Both sides use the codebase's order/accepted/done handshake.

## Interface
- NREQ, 2, number of requesters (2..4); index width IW = 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- order_i  in  NREQ  per-requester operation request (level)
- rs1_i  in  32*NREQ  operand 1, requester k at bits [32k+31:32k]
- rs2_i  in  32*NREQ  operand 2, same packing
- accepted_o  out  NREQ  one-hot, combinational grant pulse
- done_o  out  NREQ  one-hot, registered completion pulse
- rd_o  out  32  registered product; valid in the done_o cycle, held until the next capture
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky protocol error
- fmul_order  out  1  to multiplier `order`
- fmul_accepted  in  1  from multiplier `accepted`
- fmul_done  in  1  from multiplier `done`
- fmul_rs1, fmul_rs2  out  32  latched operands
- fmul_rd  in  32  multiplier result

## Operation
- Registers:
  - state: IDLE, ISSUE, WAIT, RESP
  - grant index g
  - round-robin pointer ptr
  - operand registers op1, op2
  - rd_o, done_o, err_o
- IDLE:
  - Scan order_i from ptr upward, wrapping modulo NREQ. The first set bit is the winner w.
  - If a winner exists: accepted_o[w]=1 in the same cycle; op1/op2 <= rs1_i/rs2_i slice w; g <= w; ptr <= (w+1) mod NREQ; go to ISSUE.
  - If no bit is set: stay in IDLE with accepted_o=0.
- ISSUE:
  - fmul_order=1.
  - If fmul_accepted, go to WAIT; otherwise hold fmul_order high and stay.
- WAIT:
  - fmul_order=0.
  - On fmul_done: rd_o <= fmul_rd, done_o <= one-hot(g), go to RESP.
- RESP:
  - done_o is visible for exactly this cycle; it clears on exit.
  - Return to IDLE. No grant is made in RESP.
- fmul_rs1/fmul_rs2 = op1/op2 in every state. They change only on a grant.
- accepted_o is 0 outside IDLE.
- order_i is sampled only in IDLE:
  - Deasserting order_i before grant withdraws the request with no side effects.
  - A requester still asserting order_i in the next IDLE cycle is treated as a new operation. Requesters must drop order_i after accepted unless they intend to issue again.
- fmul_done in IDLE, ISSUE or RESP: set err_o, ignore the result, no state change.
- Zero/denormal/sign handling belongs entirely to the multiplier. Data passes through unmodified.

## Timing
- Reset (async assert, sync release): state=IDLE, ptr=0, g=0, op1=op2=0, rd_o=0, done_o=0, err_o=0, fmul_order=0, busy_o=0. accepted_o is forced to 0 while rst=1.
- Reset mid-operation: the in-flight operation is discarded and no done_o is produced. The multiplier shares rst and is cleared with it.
- Latency with an idle multiplier (fmul_accepted in the ISSUE cycle, fmul_done 3 cycles later), order_i at cycle 0:
  - cycle 0: accepted_o
  - cycle 1: ISSUE
  - cycles 2-4: WAIT, fmul_done at cycle 4
  - cycle 5: done_o
- Throughput: at most one operation per 6 cycles; the next grant is possible in the cycle after RESP.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep waiting and are served in rotation; starvation-free.
- ptr wraps from NREQ-1 to 0.

## Test plan
- Single request, NREQ=2: order_i=01, rs1=0x40400000 (3.0), rs2=0xC0000000 (-2.0) -> accepted_o=01 at cycle 0, done_o=01 at cycle 5, rd_o=0xC0C00000.
- Contention: order_i=11 held every cycle from reset -> grants alternate 01,10,01,10. done_o matches each grant; each rd_o matches its own operands (ports use distinct operands 1.5×2.0=0x40400000 and 0.5×0.5=0x3E800000).
- Operand stability: change rs1_i/rs2_i every cycle after accepted -> fmul_rs1/fmul_rs2 constant until the next grant; rd_o reflects the latched values.
- Stalled acceptance: hold fmul_accepted=0 for 4 cycles in ISSUE -> fmul_order stays 1 throughout, no second accepted_o, done_o delayed by 4 cycles.
- Reset mid-WAIT: assert rst at cycle 3 -> all outputs 0 immediately; no done_o after release; a new order_i=10 is served normally with ptr=0.
- Protocol error: pulse fmul_done while IDLE -> err_o=1 and stays 1, no done_o, rd_o unchanged; cleared only by rst.
